// File: rtl/kernel_rr_node_arbiter.sv
// Round-robin arbiter that shares one fixed-latency two-operand leaf node among
// NREQ requesters, tagging each issue and steering the result back to its owner.
module kernel_rr_node_arbiter #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDXW    = 2,
  parameter int unsigned LAT     = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*STREAMW-1:0]  req_in1,
  input  logic [NREQ*STREAMW-1:0]  req_in2,
  output logic [NREQ-1:0]          req_ready,
  output logic                     node_ivalid,
  output logic [STREAMW-1:0]       node_in1,
  output logic [STREAMW-1:0]       node_in2,
  input  logic                     node_iready,
  output logic                     node_oready,
  input  logic                     node_ovalid,
  input  logic [STREAMW-1:0]       node_out,
  output logic [NREQ-1:0]          res_valid,
  output logic [NREQ*STREAMW-1:0]  res_data,
  input  logic [NREQ-1:0]          res_ready,
  output logic [CNTW-1:0]          ops_done,
  output logic                     tag_err
);

  localparam logic [3:0] QUIET_INIT = 4'(LAT);

  logic [NREQ-1:0] inflight;
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] last;
  logic            tag_v   [LAT];
  logic [IDXW-1:0] tag_idx [LAT];
  logic            wb_v;
  logic [IDXW-1:0] wb_idx;
  logic [3:0]      quiet;

  assign busy        = inflight | res_valid;
  assign eligible    = req_valid & ~busy & {NREQ{node_iready}};
  assign req_ready   = grant;
  assign node_ivalid = |grant;
  assign node_oready = 1'b1;
  assign wb_v        = tag_v[LAT-1];
  assign wb_idx      = tag_idx[LAT-1];

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(last) + off) % NREQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

  always_comb begin
    node_in1 = '0;
    node_in2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        node_in1 = req_in1[i*STREAMW +: STREAMW];
        node_in2 = req_in2[i*STREAMW +: STREAMW];
      end
    end
  end

  // quiet masks tag/ovalid mismatches for LAT cycles after reset, while results
  // of operations issued before reset are still draining out of the node.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
      last      <= IDXW'(NREQ-1);
      inflight  <= '0;
      res_valid <= '0;
      res_data  <= '0;
      ops_done  <= '0;
      tag_err   <= 1'b0;
      quiet     <= QUIET_INIT;
    end else begin
      tag_v[0]   <= |grant;
      tag_idx[0] <= grant_idx;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      if (|grant) last <= grant_idx;
      if (quiet != 4'd0) quiet <= quiet - 4'd1;
      else if (wb_v != node_ovalid) tag_err <= 1'b1;
      if (wb_v) ops_done <= ops_done + 1'b1;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (wb_v && wb_idx == IDXW'(i)) begin
          res_valid[i]                  <= 1'b1;
          res_data[i*STREAMW +: STREAMW] <= node_out;
          inflight[i]                   <= 1'b0;
        end else if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
        end
        if (grant[i]) inflight[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_rr_node_arbiter.sv
// Bench for kernel_rr_node_arbiter: a behavioural adder node plus a per-requester
// reference model of arbitration, result routing, counting and tag checking.
module tb_kernel_rr_node_arbiter;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDXW = 2;
  localparam int LAT  = 1;
  localparam int CNTW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_in1, req_in2;
  logic [NREQ-1:0]     req_ready;
  logic                node_ivalid;
  logic [W-1:0]        node_in1, node_in2;
  logic                node_iready;
  logic                node_oready;
  logic                node_ovalid;
  logic [W-1:0]        node_out;
  logic [NREQ-1:0]     res_valid;
  logic [NREQ*W-1:0]   res_data;
  logic [NREQ-1:0]     res_ready;
  logic [CNTW-1:0]     ops_done;
  logic                tag_err;

  logic                inject;
  logic                node_clr;
  logic                pv [LAT];
  logic [W-1:0]        pd [LAT];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] a [NREQ];
  logic [W-1:0] b [NREQ];

  // reference model state
  int           m_due [NREQ];
  logic [W-1:0] m_val [NREQ];
  logic         m_rv  [NREQ];
  logic [W-1:0] m_rd  [NREQ];
  int           m_last;
  logic [15:0]  m_ops;
  logic         m_terr;
  int           m_quiet;

  kernel_rr_node_arbiter #(.STREAMW(W), .NREQ(NREQ), .IDXW(IDXW), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
    .req_ready(req_ready), .node_ivalid(node_ivalid), .node_in1(node_in1), .node_in2(node_in2),
    .node_iready(node_iready), .node_oready(node_oready), .node_ovalid(node_ovalid),
    .node_out(node_out), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .ops_done(ops_done), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  // leaf node: sum with LAT cycles of latency, not cleared by the arbiter reset
  always @(posedge clk) begin
    if (node_clr) begin
      for (int s = 0; s < LAT; s++) begin pv[s] <= 1'b0; pd[s] <= '0; end
    end else begin
      pv[0] <= node_ivalid & node_iready;
      pd[0] <= node_in1 + node_in2;
      for (int s = 1; s < LAT; s++) begin pv[s] <= pv[s-1]; pd[s] <= pd[s-1]; end
    end
  end
  assign node_ovalid = pv[LAT-1] | inject;
  assign node_out    = pd[LAT-1];

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_due[i] = 0; m_val[i] = '0; m_rv[i] = 1'b0; m_rd[i] = '0;
    end
    m_last = NREQ - 1; m_ops = '0; m_terr = 1'b0; m_quiet = LAT;
  endtask

  function automatic int pick();
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (m_last + off) % NREQ;
      if (req_valid[i] && node_iready && m_due[i] == 0 && !m_rv[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr,
                      input logic ir, input logic inj);
    int  g;
    logic due;
    @(negedge clk);
    rst = r; req_valid = v; res_ready = rr; node_iready = ir; inject = inj;
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*W +: W] = a[i];
      req_in2[i*W +: W] = b[i];
    end
    #1;
    g = pick();
    chk("req_ready", W'(req_ready), (g >= 0) ? W'(1) << g : '0);
    chk("node_ivalid", W'(node_ivalid), W'(g >= 0));
    chk("node_in1", node_in1, (g >= 0) ? a[g] : '0);
    chk("node_in2", node_in2, (g >= 0) ? b[g] : '0);
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("res_valid%0d", i), W'(res_valid[i]), W'(m_rv[i]));
      chk($sformatf("res_data%0d", i), res_data[i*W +: W], m_rd[i]);
    end
    chk("ops_done", W'(ops_done), W'(m_ops));
    chk("tag_err", W'(tag_err), W'(m_terr));
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      due = 1'b0;
      for (int i = 0; i < NREQ; i++) if (m_due[i] == 1) due = 1'b1;
      if (m_quiet == 0 && inj && !due) m_terr = 1'b1;
      if (m_quiet > 0) m_quiet--;
      for (int i = 0; i < NREQ; i++) begin
        if (m_rv[i] && rr[i]) m_rv[i] = 1'b0;
        if (m_due[i] == 1) begin
          m_rv[i] = 1'b1; m_rd[i] = m_val[i]; m_ops++; m_due[i] = 0;
        end else if (m_due[i] > 1) begin
          m_due[i]--;
        end
      end
      if (g >= 0) begin
        m_due[g] = LAT; m_val[g] = a[g] + b[g]; m_last = g;
      end
    end
  endtask

  initial begin
    rst = 1'b1; node_clr = 1'b1; inject = 1'b0; node_iready = 1'b1;
    req_valid = '0; res_ready = '0; req_in1 = '0; req_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    node_clr = 1'b0;

    // single requester: 5 + 7, held until consumed
    a[0] = 32'd5; b[0] = 32'd7;
    repeat (6) step(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    chk("plan_sum0", res_data[31:0], 32'd12);
    chk("plan_ops1", W'(ops_done), 32'd1);
    repeat (2) step(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    repeat (2) step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);

    // all four active with continuous consume
    for (int i = 0; i < NREQ; i++) begin a[i] = W'(i * 10); b[i] = W'(i); end
    repeat (24) step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);

    // requester 2 withholds consume
    repeat (10) step(1'b0, 4'b1111, 4'b1011, 1'b1, 1'b0);
    chk("plan_hold2", res_data[2*W +: W], 32'd22);
    repeat (6) step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);

    // node not ready for three cycles
    repeat (3) step(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    repeat (6) step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; b[i] = $urandom; end
      step(1'b0, 4'($urandom), 4'($urandom), ($urandom % 4) != 0, 1'b0);
    end

    // drain, then a node result with no tag behind it
    repeat (4) step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("plan_tag_err", W'(tag_err), 32'd1);

    // reset while operations are outstanding; the reset-cycle issue comes back stale
    for (int i = 0; i < NREQ; i++) begin a[i] = W'(100 + i); b[i] = W'(i); end
    repeat (3) step(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("plan_rst_ops", W'(ops_done), 32'd0);
    repeat (6) step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; b[i] = $urandom; end
      step(($urandom % 64) == 0, 4'($urandom), 4'($urandom), ($urandom % 5) != 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
